mem_ctrl_mmio_gen2: RTL
=======================

Name: mem_ctrl_mmio_gen2

Overview:
Second-generation data-side memory controller. Sits between the core's data-memory port and two targets: a synchronous block RAM, and NUM_PER memory-mapped peripheral channels that use a req/ack handshake.
- Byte lanes are generalised: byte, half or word size, with sign or zero extension on reads.
- Adds a real stall FSM. mem_hold is asserted until the data is valid.
- Adds error reporting for misaligned, unmapped and timed-out accesses.

Parameters:
RAM_AW, 16, byte-address width of the RAM region; RAM occupies addresses [0, 2^RAM_AW).
NUM_PER, 4, number of peripheral channels (1..16).
PER_BASE, 20'haaaaa, value of addr[31:12] that selects the MMIO page.
TIMEOUT, 255, maximum number of cycles spent waiting for per_ack before an error (1..65535).

Ports:
clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
mem_wea  in  1  core write request
mem_rea  in  1  core read request
mem_addr  in  32  byte address
mem_size  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal
mem_unsigned  in  1  1 = zero-extend read data, 0 = sign-extend
mem_din  in  32  write data, right-aligned
mem_dout  out  32  read data, right-aligned and extended
mem_hold  out  1  stall the core; the core holds all request inputs stable while it is high
mem_err  out  1  one-cycle error pulse
ram_en  out  1  RAM enable
ram_we  out  4  RAM byte-lane write enables
ram_addr  out  RAM_AW-2  RAM word address
ram_din  out  32  lane-positioned write data
ram_dout  in  32  RAM read data, valid one cycle after ram_en
per_req  out  NUM_PER  one-hot request, held at level until ack
per_we  out  1  peripheral write strobe qualifier
per_addr  out  8  offset within the channel, equal to addr[7:0]
per_wdata  out  32  equal to mem_din
per_rdata  in  NUM_PER*32  per-channel read data; channel k occupies bits [32k+31:32k]
per_ack  in  NUM_PER  per-channel completion; read data is valid in the ack cycle

Behaviour:
- Reset (Rst=0, asynchronous): state=IDLE. All outputs are 0: mem_hold, mem_err, ram_en, ram_we, per_req, mem_dout. The timeout counter clears to 0. Reset mid-access abandons the access; per_req drops immediately.
- Request: mem_wea | mem_rea. When both are high, the access is a write.
- Decode order, evaluated in IDLE:
  - illegal size, or misaligned address (half with addr[0]=1; word with addr[1:0]!=0) -> ERR;
  - else addr < 2^RAM_AW -> RAM;
  - else addr[31:12]==PER_BASE and addr[11:8] < NUM_PER -> PER channel addr[11:8];
  - else -> ERR.
- Lanes:
  - Byte uses lane addr[1:0]. Half uses lanes {addr[1]*2+1, addr[1]*2}. Word uses all 4 lanes.
  - ram_din replicates mem_din into the selected lanes.
  - Read data is extracted from the selected lanes, then sign- or zero-extended per mem_unsigned.
- FSM states: IDLE, RAM_RD, PER_WAIT, DONE.
  - IDLE + RAM write: ram_en=1 and ram_we=lane mask, combinationally in the same cycle. mem_hold=0. Zero stall. Stay in IDLE.
  - IDLE + RAM read: ram_en=1, ram_we=0, mem_hold=1 (combinational). Next state RAM_RD. Lane mask and sign mode are registered.
  - RAM_RD: mem_dout = extract(ram_dout), mem_hold=0. Next state DONE.
  - IDLE + PER access: mem_hold=1, per_req[ch]=1 (registered, asserted from the next cycle). Next state PER_WAIT. Counter clears.
  - PER_WAIT: mem_hold=1 and the counter increments.
    - On per_ack[ch]: read data is captured and extended into mem_dout; per_req drops; next state DONE.
    - If the counter reaches TIMEOUT with no ack: per_req drops, mem_dout=0, mem_err pulses; next state DONE.
    - Acks on non-selected channels are ignored.
  - DONE: mem_hold=0 and mem_dout is held. DONE lasts exactly one cycle, so the core cannot re-issue the same access and have it re-executed. Next state IDLE.
- ERR decode: mem_err=1 for one cycle. No RAM or peripheral side effects, mem_hold=0, mem_dout=0.
- mem_dout holds its last value in all states except RAM_RD and per-ack/timeout capture.
- Latencies, in stall cycles: RAM write 0, RAM read 1, peripheral ack latency + 1, timeout TIMEOUT + 1.

Test Plan:
- Byte read, sign/zero: RAM word 0x0000_0010 = 0x80FF_7F01. Read byte at 0x12 with mem_unsigned=0 -> mem_dout=0xFFFF_FFFF after 1 hold cycle. Same read with mem_unsigned=1 -> 0x0000_00FF.
- Half write, no stall: half 0xBEEF to 0x16 -> ram_we=4'b1100 and ram_din=0xBEEF_BEEF in the same cycle, mem_hold=0. Word read of 0x14 -> 0xBEEF_xxxx, lower half unchanged.
- Peripheral ack: read 0xAAAAA204, with ch2 acking 3 cycles after per_req rises and per_rdata ch2=0x0000_0041 -> per_req=4'b0100, mem_hold high 4 cycles, mem_dout=0x41, mem_err=0.
- Peripheral timeout: with TIMEOUT=8, write 0xAAAAA300 and never ack -> per_req drops after 8 wait cycles, mem_err single pulse, mem_hold falls.
- Misaligned and unmapped: word read of 0x0000_0002 -> mem_err=1, ram_en=0. Access to 0xAAAAA500 with NUM_PER=4 -> mem_err=1, per_req=0.
- Reset mid-access: assert Rst=0 during PER_WAIT -> per_req=0 and mem_hold=0 asynchronously. After release, state is IDLE and the next RAM read works.

Source files
------------

// File: rtl/mem_ctrl_mmio_gen2_if.sv
// Core-side data-memory port of mem_ctrl_mmio_gen2: request, address, size and data,
// plus the stall/error/read-data response returned to the core.
interface mem_ctrl_mmio_gen2_if;
    logic        mem_wea;
    logic        mem_rea;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_hold;
    logic        mem_err;

    modport master (
        output mem_wea, mem_rea, mem_addr, mem_size, mem_unsigned, mem_din,
        input  mem_dout, mem_hold, mem_err
    );

    modport slave (
        input  mem_wea, mem_rea, mem_addr, mem_size, mem_unsigned, mem_din,
        output mem_dout, mem_hold, mem_err
    );
endinterface

// File: rtl/mem_ctrl_mmio_gen2.sv
// Data-side memory controller: routes core accesses to a sync block RAM or to one of
// NUM_PER req/ack peripheral channels, with byte/half/word lanes and error reporting.
module mem_ctrl_mmio_gen2 #(
    parameter int          RAM_AW   = 16,
    parameter int          NUM_PER  = 4,
    parameter logic [19:0] PER_BASE = 20'haaaaa,
    parameter int          TIMEOUT  = 255
) (
    input  logic                   clk,
    input  logic                   Rst,
    mem_ctrl_mmio_gen2_if.slave    core,
    output logic                   ram_en,
    output logic [3:0]             ram_we,
    output logic [RAM_AW-3:0]      ram_addr,
    output logic [31:0]            ram_din,
    input  logic [31:0]            ram_dout,
    output logic [NUM_PER-1:0]     per_req,
    output logic                   per_we,
    output logic [7:0]             per_addr,
    output logic [31:0]            per_wdata,
    input  logic [NUM_PER*32-1:0]  per_rdata,
    input  logic [NUM_PER-1:0]     per_ack
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RAM_RD   = 2'd1;
    localparam logic [1:0] PER_WAIT = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]  state;
    logic [15:0] cnt_p1;
    logic [3:0]  ch_p1;
    logic [1:0]  sz_p1;
    logic [1:0]  off_p1;
    logic        uns_p1;
    logic [31:0] dout_p1;
    logic        err_p1;

    logic        req;
    logic        is_wr;
    logic        misaligned;
    logic        hit_ram;
    logic        hit_per;
    logic        idle_req;
    logic        dec_err;
    logic        dec_ram;
    logic        dec_per;
    logic [31:0] sel_rdata;
    logic        sel_ack;
    logic [31:0] ram_ext;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Accesses are aligned, so shifting by the byte offset right-aligns every size.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic uns);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        sh = w >> {off, 3'b000};
        b  = sh[7:0];
        h  = sh[15:0];
        case (sz)
            2'b00:   s = uns ? $signed({24'd0, sh[7:0]})  : 32'(b);
            2'b01:   s = uns ? $signed({16'd0, sh[15:0]}) : 32'(h);
            default: s = $signed(sh);
        endcase
        return s;
    endfunction

    assign req        = core.mem_wea | core.mem_rea;
    assign is_wr      = core.mem_wea;
    assign misaligned = (core.mem_size == 2'b11)
                      | ((core.mem_size == 2'b01) & core.mem_addr[0])
                      | ((core.mem_size == 2'b10) & (core.mem_addr[1:0] != 2'b00));
    assign hit_ram    = (core.mem_addr[31:RAM_AW] == '0);
    assign hit_per    = (core.mem_addr[31:12] == PER_BASE)
                      & ({1'b0, core.mem_addr[11:8]} < 5'(NUM_PER));

    // Decode only while idle and out of reset so nothing leaks out during Rst.
    assign idle_req = Rst & (state == IDLE) & req;
    assign dec_err  = idle_req & (misaligned | ~(hit_ram | hit_per));
    assign dec_ram  = idle_req & ~misaligned & hit_ram;
    assign dec_per  = idle_req & ~misaligned & ~hit_ram & hit_per;

    always_comb begin
        sel_rdata = '0;
        sel_ack   = 1'b0;
        for (int k = 0; k < NUM_PER; k++) begin
            if (ch_p1 == 4'(k)) begin
                sel_rdata = per_rdata[32*k +: 32];
                sel_ack   = per_ack[k];
            end
        end
    end

    assign ram_ext   = extract(ram_dout, sz_p1, off_p1, uns_p1);

    assign ram_en    = dec_ram;
    assign ram_we    = (dec_ram & is_wr) ? lane_mask(core.mem_size, core.mem_addr[1:0]) : 4'b0000;
    assign ram_addr  = core.mem_addr[RAM_AW-1:2];
    assign ram_din   = replicate(core.mem_size, core.mem_din);
    assign per_addr  = core.mem_addr[7:0];
    assign per_wdata = core.mem_din;

    assign core.mem_hold = (dec_ram & ~is_wr) | dec_per | (state == PER_WAIT);
    assign core.mem_err  = err_p1 | dec_err;
    assign core.mem_dout = (state == RAM_RD) ? ram_ext :
                           dec_err           ? 32'd0   : dout_p1;

    // Stage p1: access context captured in IDLE, response captured on completion.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state   <= IDLE;
            cnt_p1  <= '0;
            ch_p1   <= '0;
            sz_p1   <= '0;
            off_p1  <= '0;
            uns_p1  <= 1'b0;
            dout_p1 <= '0;
            err_p1  <= 1'b0;
            per_req <= '0;
            per_we  <= 1'b0;
        end else begin
            err_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    sz_p1  <= core.mem_size;
                    off_p1 <= core.mem_addr[1:0];
                    uns_p1 <= core.mem_unsigned;
                    if (dec_ram & ~is_wr) begin
                        state <= RAM_RD;
                    end else if (dec_per) begin
                        state   <= PER_WAIT;
                        cnt_p1  <= '0;
                        ch_p1   <= core.mem_addr[11:8];
                        per_req <= NUM_PER'(1) << core.mem_addr[11:8];
                        per_we  <= is_wr;
                    end
                end
                RAM_RD: begin
                    dout_p1 <= ram_ext;
                    state   <= DONE;
                end
                PER_WAIT: begin
                    cnt_p1 <= cnt_p1 + 16'd1;
                    if (sel_ack) begin
                        if (!per_we)
                            dout_p1 <= extract(sel_rdata, sz_p1, off_p1, uns_p1);
                        per_req <= '0;
                        per_we  <= 1'b0;
                        state   <= DONE;
                    end else if (cnt_p1 == 16'(TIMEOUT - 1)) begin
                        dout_p1 <= '0;
                        err_p1  <= 1'b1;
                        per_req <= '0;
                        per_we  <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
